// File: rtl/vend_universal_reg_pkg.sv
// Shared encodings for the vending datapath universal register.
// The vending FSM imports the same mode names and default width.
package vend_universal_reg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;
    localparam int unsigned MODE_W        = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ADD  = 3'b100,
        MODE_SUB  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_UNDO = 3'b111
    } mode_e;

endpackage

// File: rtl/vend_sat_addsub.sv
// Combinational WIDTH-bit saturating add / clamping subtract.
// o_sat flags an add above all-ones or a subtract that went below zero.
module vend_sat_addsub
    import vend_universal_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_result,
    output logic             o_sat
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // The extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        o_result = w_sum[WIDTH-1:0];
        o_sat    = w_sum[WIDTH];
        if (i_sub) begin
            o_sat    = w_diff[WIDTH];
            o_result = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
        end else if (w_sum[WIDTH]) begin
            o_result = '1;
        end
    end

endmodule

// File: rtl/vend_universal_reg.sv
// WIDTH-bit universal register: load, shift, saturating add/sub, clear and
// single-level undo. i_reset is asynchronous and active-low.
module vend_universal_reg
    import vend_universal_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_ser_in,
    output logic [WIDTH-1:0]  o_q,
    output logic              o_ser_out,
    output logic              o_zero,
    output logic              o_at_max,
    output logic              o_ovf,
    output logic              o_undo_ok
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_shadow;
    logic             r_undo_ok;
    logic             r_ovf;
    logic             r_ser_out;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_arith;
    logic             w_sat;
    logic             w_capture;

    assign w_mode    = mode_e'(i_mode);
    // Every state-changing mode except UNDO snapshots the old q, even when q is unchanged.
    assign w_capture = i_en && (w_mode != MODE_HOLD) && (w_mode != MODE_UNDO);

    vend_sat_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a      (r_q),
        .i_b      (i_d),
        .i_sub    (w_mode == MODE_SUB),
        .o_result (w_arith),
        .o_sat    (w_sat)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q       <= RESET_VALUE;
            r_shadow  <= RESET_VALUE;
            r_undo_ok <= 1'b0;
            r_ovf     <= 1'b0;
            r_ser_out <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_capture) begin
                r_shadow  <= r_q;
                r_undo_ok <= 1'b1;
            end
            if (i_en) begin
                case (w_mode)
                    MODE_LOAD: r_q <= i_d;
                    MODE_SHL: begin
                        r_q       <= {r_q[WIDTH-2:0], i_ser_in};
                        r_ser_out <= r_q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        r_q       <= {i_ser_in, r_q[WIDTH-1:1]};
                        r_ser_out <= r_q[0];
                    end
                    MODE_ADD, MODE_SUB: begin
                        r_q   <= w_arith;
                        r_ovf <= w_sat;
                    end
                    MODE_CLR: r_q <= RESET_VALUE;
                    MODE_UNDO: begin
                        if (r_undo_ok) begin
                            r_q       <= r_shadow;
                            r_undo_ok <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_q       = r_q;
    assign o_ser_out = r_ser_out;
    assign o_undo_ok = r_undo_ok;
    assign o_ovf     = r_ovf;
    assign o_zero    = (r_q == '0);
    assign o_at_max  = (r_q == '1);

endmodule

// File: tb/tb_vend_universal_reg.sv
// Self-checking bench for vend_universal_reg (WIDTH=5, RESET_VALUE=0):
// arithmetic reference model compared every cycle plus directed literal checks.
module tb_vend_universal_reg;

    localparam int W   = 5;
    localparam int MAX = 31;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         ser_in;
    logic [W-1:0] q;
    logic         ser_out, zero, at_max, ovf, undo_ok;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 0;

    int m_q, m_sh, m_uok, m_ovf, m_so;

    vend_universal_reg #(
        .WIDTH       (W),
        .RESET_VALUE (5'd0)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_en      (en),
        .i_mode    (mode),
        .i_d       (d),
        .i_ser_in  (ser_in),
        .o_q       (q),
        .o_ser_out (ser_out),
        .o_zero    (zero),
        .o_at_max  (at_max),
        .o_ovf     (ovf),
        .o_undo_ok (undo_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = 0; m_sh = 0; m_uok = 0; m_ovf = 0; m_so = 0;
        end else begin
            int old_q;
            old_q = m_q;
            m_ovf = 0;
            if (en) begin
                case (int'(mode))
                    1: m_q = int'(d);
                    2: begin m_so = old_q / 16; m_q = (old_q * 2) % 32 + int'(ser_in); end
                    3: begin m_so = old_q % 2;  m_q = old_q / 2 + int'(ser_in) * 16; end
                    4: begin
                        if (old_q + int'(d) > MAX) begin m_q = MAX; m_ovf = 1; end
                        else m_q = old_q + int'(d);
                    end
                    5: begin
                        if (int'(d) > old_q) begin m_q = 0; m_ovf = 1; end
                        else m_q = old_q - int'(d);
                    end
                    6: m_q = 0;
                    7: if (m_uok == 1) begin m_q = m_sh; m_uok = 0; end
                    default: ;
                endcase
                if (mode >= 3'd1 && mode <= 3'd6) begin
                    m_sh  = old_q;
                    m_uok = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q",       int'(q),       m_q);
            check("model_ser_out", int'(ser_out), m_so);
            check("model_ovf",     int'(ovf),     m_ovf);
            check("model_undo_ok", int'(undo_ok), m_uok);
            check("model_zero",    int'(zero),    int'(m_q == 0));
            check("model_at_max",  int'(at_max),  int'(m_q == MAX));
        end
    end

    // Called at a falling edge; returns at the next falling edge with results visible.
    task automatic op(input logic e, input logic [2:0] m, input int dv, input logic s);
        en = e; mode = m; d = W'(dv); ser_in = s;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 3'd1; d = 5'd7; ser_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_q", int'(q), 0);
        check("rst_undo_ok", int'(undo_ok), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_zero", int'(zero), 1);
        @(negedge clk);
        check("rst_hold_q", int'(q), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_load_q", int'(q), 7);

        op(1, 3'd1, 20, 0);
        op(1, 3'd4, 15, 0);
        check("add_sat_q", int'(q), 31);
        check("add_sat_at_max", int'(at_max), 1);
        check("add_sat_ovf", int'(ovf), 1);
        op(1, 3'd0, 0, 0);
        check("hold_ovf_clear", int'(ovf), 0);
        check("hold_q", int'(q), 31);

        op(1, 3'd1, 10, 0);
        op(1, 3'd5, 10, 0);
        check("sub_eq_q", int'(q), 0);
        check("sub_eq_ovf", int'(ovf), 0);
        op(1, 3'd5, 3, 0);
        check("sub_clamp_q", int'(q), 0);
        check("sub_clamp_ovf", int'(ovf), 1);

        op(1, 3'd1, 19, 0);
        op(1, 3'd2, 0, 0);
        check("shl_q", int'(q), 6);
        check("shl_ser_out", int'(ser_out), 1);
        op(1, 3'd3, 0, 1);
        check("shr_q", int'(q), 19);
        check("shr_ser_out", int'(ser_out), 0);
        op(1, 3'd1, 0, 0);
        check("load_keeps_ser_out", int'(ser_out), 0);

        op(1, 3'd1, 9, 0);
        op(1, 3'd4, 4, 0);
        check("add_q", int'(q), 13);
        check("add_ovf", int'(ovf), 0);
        op(1, 3'd7, 0, 0);
        check("undo_q", int'(q), 9);
        check("undo_flag", int'(undo_ok), 0);
        op(1, 3'd7, 0, 0);
        check("undo2_q", int'(q), 9);
        op(0, 3'd1, 1, 0);
        check("en0_q", int'(q), 9);
        check("en0_ovf", int'(ovf), 0);

        op(1, 3'd6, 0, 0);
        check("clr_q", int'(q), 0);
        check("clr_undo_ok", int'(undo_ok), 1);
        op(1, 3'd7, 0, 0);
        check("undo_clr_q", int'(q), 9);

        // Short reset pulse inside a cycle with a saturating ADD pending.
        op(1, 3'd1, 30, 0);
        en = 1'b1; mode = 3'd4; d = 5'd5; ser_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_undo_ok", int'(undo_ok), 0);
        check("async_rst_ovf", int'(ovf), 0);
        check("async_rst_zero", int'(zero), 1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_add_q", int'(q), 5);
        check("post_rst_add_ovf", int'(ovf), 0);

        for (int i = 0; i < 300; i++) begin
            op(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, MAX)), 1'($urandom_range(0, 1)));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
